// File: rtl/stream_mux_pkg.sv
// Shared constants, types and index helpers for the stream_mux slice.
// Used by stream_mux, stream_mux_if and rr_grant.
package stream_mux_pkg;

   localparam int WORD_LEN = 32;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR = 1;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   // (a + b) mod n, valid for a, b < n
   function automatic int wrap_add(int a, int b, int n);
      int s;
      s = a + b;
      return (s >= n) ? s - n : s;
   endfunction

   function automatic int wrap_inc(int idx, int n);
      return wrap_add(idx, 1, n);
   endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle between N input channels and one output stream.
// master drives the inputs, slave is the mux side.
interface stream_mux_if
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = WORD_LEN,
   parameter int N = 4
);

   localparam int SW = $clog2(N);

   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [SW-1:0]      sel;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SW-1:0]      out_chan;

   modport master (
      output in_data,
      output in_valid,
      output sel,
      output out_ready,
      input  in_ready,
      input  out_data,
      input  out_valid,
      input  out_chan
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  sel,
      input  out_ready,
      output in_ready,
      output out_data,
      output out_valid,
      output out_chan
   );

endinterface

// File: rtl/stream_mux_rr_grant.sv
// Round-robin arbiter: first valid channel scanning upward from start,
// wrapping from N-1 to 0.
module rr_grant
   import stream_mux_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid,
   input  logic [$clog2(N)-1:0] start,
   output logic [$clog2(N)-1:0] grant,
   output logic                 found
);

   localparam int SW = $clog2(N);

   // Scan farthest offset first so the nearest valid channel wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (valid[SW'(wrap_add(int'(start), i, N))]) begin
            grant = SW'(wrap_add(int'(start), i, N));
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 stream mux with a registered output stage, fixed or round-robin.
// Define STREAM_MUX_STATS_EN to add the saturating xfer_cnt output.
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = WORD_LEN,
   parameter int N = 4,
   parameter int MODE = MODE_FIXED
) (
   input logic         clk,
   input logic         rst,
   stream_mux_if.slave bus
`ifdef STREAM_MUX_STATS_EN
   ,
   output logic [15:0] xfer_cnt
`endif
);

   localparam int SW = $clog2(N);

   out_state_e state_q;
   out_state_e state_d;

   logic             can_load;
   logic             grant_ok;
   logic             xfer;
   logic [SW-1:0]    grant;
   logic [WIDTH-1:0] grant_data;
   logic [WIDTH-1:0] data_q;
   logic [SW-1:0]    chan_q;

   generate
      if (MODE == MODE_RR) begin : g_rr
         logic [SW-1:0] rr_ptr;

         rr_grant #(
            .N(N)
         ) u_rr_grant (
            .valid(bus.in_valid),
            .start(rr_ptr),
            .grant(grant),
            .found(grant_ok)
         );

         always_ff @(posedge clk) begin
            if (rst) begin
               rr_ptr <= '0;
            end else if (xfer) begin
               rr_ptr <= SW'(wrap_inc(int'(grant), N));
            end
         end
      end else begin : g_fixed
         // sel may exceed N-1 when N is not a power of two
         assign grant = bus.sel;
         assign grant_ok = (int'(bus.sel) < N);
      end
   endgenerate

   assign grant_data = bus.in_data[grant*WIDTH +: WIDTH];

   always_comb begin
      can_load = (state_q == EMPTY) || bus.out_ready;
      bus.in_ready = '0;
      xfer = 1'b0;
      if (!rst && can_load && grant_ok) begin
         bus.in_ready = {{(N-1){1'b0}}, 1'b1} << grant;
         xfer = bus.in_valid[grant];
      end
      state_d = state_q;
      if (xfer) begin
         state_d = FULL;
      end else if (bus.out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         chan_q <= '0;
      end else if (xfer) begin
         data_q <= grant_data;
         chan_q <= grant;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data = data_q;
   assign bus.out_chan = chan_q;

`ifdef STREAM_MUX_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt <= '0;
      end else if (xfer && xfer_cnt != CNT_MAX) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: fixed-select (N=3) and round-robin (N=4)
// instances checked against a per-cycle behavioural model.
module tb_stream_mux;
   import stream_mux_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   stream_mux_if #(.WIDTH(32), .N(3)) b0();
   stream_mux_if #(.WIDTH(32), .N(4)) b1();

`ifdef STREAM_MUX_STATS_EN
   logic [15:0] cnt0;
   logic [15:0] cnt1;
`endif

   stream_mux #(
      .WIDTH(32), .N(3), .MODE(MODE_FIXED)
   ) dut0 (
      .clk(clk),
      .rst(rst),
      .bus(b0)
`ifdef STREAM_MUX_STATS_EN
      ,
      .xfer_cnt(cnt0)
`endif
   );

   stream_mux #(
      .WIDTH(32), .N(4), .MODE(MODE_RR)
   ) dut1 (
      .clk(clk),
      .rst(rst),
      .bus(b1)
`ifdef STREAM_MUX_STATS_EN
      ,
      .xfer_cnt(cnt1)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic [2:0]   v0;
   logic [95:0]  d0;
   logic [1:0]   s0;
   logic         r0;
   logic [3:0]   v1;
   logic [127:0] d1;
   logic         r1;

   bit          m0_v;
   logic [31:0] m0_d;
   int          m0_c;
   int          m0_n;
   bit          m1_v;
   logic [31:0] m1_d;
   int          m1_c;
   int          m1_p;
   int          m1_n;

   task automatic model_reset();
      m0_v = 0; m0_d = '0; m0_c = 0; m0_n = 0;
      m1_v = 0; m1_d = '0; m1_c = 0; m1_p = 0; m1_n = 0;
   endtask

   // One clock: drive, check in_ready, advance model, check outputs.
   task automatic cycle();
      int g1;
      logic [2:0] e0;
      logic [3:0] e1;
      bit x0;
      bit x1;
      b0.in_valid = v0; b0.in_data = d0; b0.sel = s0; b0.out_ready = r0;
      b1.in_valid = v1; b1.in_data = d1; b1.sel = '0; b1.out_ready = r1;
      #1;
      e0 = '0; x0 = 0;
      if (!rst && (!m0_v || r0) && s0 < 2'd3) begin
         e0 = 3'(1 << s0);
         x0 = v0[s0];
      end
      g1 = -1;
      for (int k = 0; k < 4; k++)
         if (g1 < 0 && v1[(m1_p + k) % 4]) g1 = (m1_p + k) % 4;
      e1 = '0; x1 = 0;
      if (!rst && (!m1_v || r1) && g1 >= 0) begin
         e1 = 4'(1 << g1);
         x1 = 1;
      end
      checks++;
      if (b0.in_ready !== e0) begin
         errors++;
         $display("FAIL in_ready0 got %b exp %b", b0.in_ready, e0);
      end
      checks++;
      if (b1.in_ready !== e1) begin
         errors++;
         $display("FAIL in_ready1 got %b exp %b", b1.in_ready, e1);
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (x0) begin
            m0_v = 1; m0_d = d0[s0*32 +: 32]; m0_c = int'(s0);
            if (m0_n < 65535) m0_n++;
         end else if (r0) m0_v = 0;
         if (x1) begin
            m1_v = 1; m1_d = d1[g1*32 +: 32]; m1_c = g1;
            m1_p = (g1 + 1) % 4;
            if (m1_n < 65535) m1_n++;
         end else if (r1) m1_v = 0;
      end
      @(negedge clk);
      checks++;
      if (b0.out_valid !== m0_v || b0.out_data !== m0_d
          || b0.out_chan !== 2'(m0_c)) begin
         errors++;
         $display("FAIL out0 got v%b d%h c%0d exp v%b d%h c%0d",
            b0.out_valid, b0.out_data, b0.out_chan, m0_v, m0_d, m0_c);
      end
      checks++;
      if (b1.out_valid !== m1_v || b1.out_data !== m1_d
          || b1.out_chan !== 2'(m1_c)) begin
         errors++;
         $display("FAIL out1 got v%b d%h c%0d exp v%b d%h c%0d",
            b1.out_valid, b1.out_data, b1.out_chan, m1_v, m1_d, m1_c);
      end
`ifdef STREAM_MUX_STATS_EN
      checks++;
      if (cnt0 !== 16'(m0_n) || cnt1 !== 16'(m1_n)) begin
         errors++;
         $display("FAIL xfer_cnt got %0d/%0d exp %0d/%0d",
            cnt0, cnt1, m0_n, m1_n);
      end
`endif
   endtask

   task automatic idle();
      v0 = '0; d0 = {$urandom, $urandom, $urandom}; s0 = '0; r0 = 1;
      v1 = '0; d1 = {$urandom, $urandom, $urandom, $urandom}; r1 = 1;
   endtask

   task automatic test_reset();
      rst = 1;
      idle();
      v0 = 3'b111; v1 = 4'hF;
      cycle();
      cycle();
      checks++;
      if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0
          || b1.out_data !== 32'd0 || b1.out_chan !== 2'd0) begin
         errors++;
         $display("FAIL reset_out got v%b v%b d%h c%0d exp 0",
            b0.out_valid, b1.out_valid, b1.out_data, b1.out_chan);
      end
      checks++;
      if (b0.in_ready !== 3'b000 || b1.in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready got %b %b exp 0",
            b0.in_ready, b1.in_ready);
      end
      rst = 0;
   endtask

   task automatic test_fixed_select();
      idle();
      d0 = {32'd20, 32'd10, 32'd30};
      s0 = 2'd1; v0 = 3'b111; r0 = 1;
      cycle();
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_data !== 32'd10
          || b0.out_chan !== 2'd1) begin
         errors++;
         $display("FAIL fixed_sel got v%b d%0d c%0d exp v1 d10 c1",
            b0.out_valid, b0.out_data, b0.out_chan);
      end
      checks++;
      if (b0.in_ready !== 3'b010) begin
         errors++;
         $display("FAIL fixed_ready got %b exp 010", b0.in_ready);
      end
   endtask

   task automatic test_fixed_out_of_range();
      idle();
      s0 = 2'd3; v0 = 3'b111; r0 = 1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if (b0.in_ready !== 3'b000 || b0.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sel_oob got rdy %b v%b exp 000 v0",
               b0.in_ready, b0.out_valid);
         end
      end
   endtask

   task automatic test_round_robin();
      idle();
      rst = 1;
      cycle();
      rst = 0;
      v1 = 4'hF; r1 = 1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++;
         if (b1.out_valid !== 1'b1 || b1.out_chan !== 2'(i % 4)) begin
            errors++;
            $display("FAIL rr_seq got v%b c%0d exp v1 c%0d",
               b1.out_valid, b1.out_chan, i % 4);
         end
      end
   endtask

   task automatic test_rr_stall();
      idle();
      d1[2*32 +: 32] = 32'd7;
      v1 = 4'b0100; r1 = 1;
      cycle();
      v1 = 4'hF; r1 = 0;
      d1 = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (b1.out_data !== 32'd7 || b1.out_valid !== 1'b1
             || b1.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rr_stall got d%0d v%b rdy %b exp d7 v1 0000",
               b1.out_data, b1.out_valid, b1.in_ready);
         end
      end
      r1 = 1;
      cycle();
      checks++;
      if (b1.out_chan !== 2'd3 || b1.out_data !== d1[3*32 +: 32]) begin
         errors++;
         $display("FAIL rr_resume got c%0d d%h exp c3 d%h",
            b1.out_chan, b1.out_data, d1[3*32 +: 32]);
      end
   endtask

   task automatic test_reset_while_full();
      idle();
      v1 = 4'hF; r1 = 0;
      cycle();
      checks++;
      if (b1.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_before_rst got v%b exp 1", b1.out_valid);
      end
      rst = 1;
      cycle();
      rst = 0;
      checks++;
      if (b1.out_valid !== 1'b0 || b1.out_data !== 32'd0) begin
         errors++;
         $display("FAIL rst_full got v%b d%h exp v0 d0",
            b1.out_valid, b1.out_data);
      end
      r1 = 1;
      cycle();
      checks++;
      if (b1.out_chan !== 2'd0 || b1.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rr_restart got c%0d v%b exp c0 v1",
            b1.out_chan, b1.out_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         v0 = 3'($urandom); s0 = 2'($urandom);
         d0 = {$urandom, $urandom, $urandom};
         r0 = ($urandom_range(0, 3) != 0);
         v1 = 4'($urandom);
         d1 = {$urandom, $urandom, $urandom, $urandom};
         r1 = ($urandom_range(0, 3) != 0);
         cycle();
      end
      rst = 0;
   endtask

`ifdef STREAM_MUX_STATS_EN
   task automatic test_stats();
      idle();
      rst = 1;
      cycle();
      rst = 0;
      v0 = 3'b001; s0 = 2'd0; r0 = 1;
      repeat (5) cycle();
      checks++;
      if (cnt0 !== 16'd5) begin
         errors++;
         $display("FAIL stats_5 got %0d exp 5", cnt0);
      end
      repeat (65530) cycle();
      checks++;
      if (cnt0 !== 16'hFFFF) begin
         errors++;
         $display("FAIL stats_max got %h exp ffff", cnt0);
      end
      cycle();
      checks++;
      if (cnt0 !== 16'hFFFF) begin
         errors++;
         $display("FAIL stats_sat got %h exp ffff", cnt0);
      end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_fixed_select();
      test_fixed_out_of_range();
      test_round_robin();
      test_rr_stall();
      test_reset_while_full();
      test_random();
`ifdef STREAM_MUX_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors",
         checks, errors);
      $finish;
   end

endmodule
